// File: rtl/cobs_pkg.sv
// rtl/cobs_pkg.sv - shared COBS state type, constants and code-byte helper
package cobs_pkg;

    typedef enum logic [2:0] {
        RESYNC,
        IDLE,
        CODE,
        EMIT,
        DELIM
    } cobs_state_t;

    localparam logic [7:0] COBS_DELIM     = 8'h00;
    localparam int         COBS_MAX_BLOCK = 254;

    // Distance from p to the next zero at or after p (1-based), or to one past the end.
    function automatic logic [7:0] cobs_code(
        input logic [7:0] payload [COBS_MAX_BLOCK],
        input int         p,
        input int         len
    );
        int code;
        code = len - p + 1;
        for (int i = COBS_MAX_BLOCK - 1; i >= 0; i--) begin
            if (i >= p && i < len && payload[i] == COBS_DELIM) begin
                code = i - p + 1;
            end
        end
        return code[7:0];
    endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - combinational round-robin arbiter, search starts after last_grant
module axis_rr_arbiter #(
    parameter int CHANNELS = 2,
    parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    last_grant,
    output logic [CHANNELS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(last_grant) + i) % CHANNELS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axis_cobs_mux_encoder.sv
// rtl/axis_cobs_mux_encoder.sv - round-robin multi-channel COBS frame encoder onto one byte stream
module axis_cobs_mux_encoder
    import cobs_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int DATA_BYTES     = 6,
    parameter int ADD_CHANNEL_ID = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [CHANNELS*8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [CHANNELS-1:0]              s_axis_tvalid,
    output logic [CHANNELS-1:0]              s_axis_tready,
    output logic [7:0]                       m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             busy,
    output logic [15:0]                      frame_count
);

    localparam int L     = DATA_BYTES + ADD_CHANNEL_ID;
    localparam int W     = 8 * DATA_BYTES;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    if (L > COBS_MAX_BLOCK || DATA_BYTES < 1 || CHANNELS < 1 || CHANNELS > 16) begin : g_param_check
        $error("axis_cobs_mux_encoder: illegal CHANNELS/DATA_BYTES/ADD_CHANNEL_ID combination");
    end

    cobs_state_t         state, state_next;
    logic [7:0]          payload  [L];
    logic [7:0]          code_buf [COBS_MAX_BLOCK];
    logic [7:0]          ptr;
    logic [7:0]          code_val;
    logic [IDX_W-1:0]    last_grant, grant_idx;
    logic [CHANNELS-1:0] grant;
    logic [W-1:0]        word;
    logic                m_hs, s_hs;

    axis_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign word          = s_axis_tdata[int'(grant_idx)*W +: W];
    assign s_axis_tready = (state == IDLE) ? grant : '0;
    assign s_hs          = (state == IDLE) && (|grant);

    // Gated by reset_n so the link goes quiet the instant reset is asserted.
    assign m_axis_tvalid = reset_n && (state != IDLE);
    assign m_axis_tlast  = reset_n && (state == RESYNC || state == DELIM);
    assign busy          = reset_n && (state != IDLE);
    assign m_hs          = m_axis_tvalid && m_axis_tready;

    always_comb begin
        for (int i = 0; i < COBS_MAX_BLOCK; i++) begin
            code_buf[i] = 8'hFF;
        end
        for (int i = 0; i < L; i++) begin
            code_buf[i] = payload[i];
        end
    end

    always_comb begin
        code_val = cobs_code(code_buf, (state == EMIT) ? int'(ptr) + 1 : 0, L);
    end

    always_comb begin
        m_axis_tdata = COBS_DELIM;
        case (state)
            CODE:    m_axis_tdata = code_val;
            EMIT:    m_axis_tdata = (code_buf[ptr] == COBS_DELIM) ? code_val : code_buf[ptr];
            default: m_axis_tdata = COBS_DELIM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RESYNC:  if (m_hs) state_next = IDLE;
            IDLE:    if (s_hs) state_next = CODE;
            CODE:    if (m_hs) state_next = EMIT;
            EMIT:    if (m_hs && ptr == 8'(L - 1)) state_next = DELIM;
            DELIM:   if (m_hs) state_next = IDLE;
            default: state_next = RESYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            last_grant  <= IDX_W'(CHANNELS - 1);
            frame_count <= '0;
            for (int i = 0; i < L; i++) begin
                payload[i] <= '0;
            end
        end else begin
            if (s_hs) begin
                ptr        <= '0;
                last_grant <= grant_idx;
                if (ADD_CHANNEL_ID != 0) begin
                    payload[0] <= 8'(grant_idx);
                end
                for (int k = 0; k < DATA_BYTES; k++) begin
                    payload[ADD_CHANNEL_ID + k] <= word[8*(DATA_BYTES-1-k) +: 8];
                end
            end
            if (state == EMIT && m_hs) begin
                ptr <= ptr + 8'd1;
            end
            if (state == DELIM && m_hs) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
